tdes_round_controller: RTL
==========================

# tdes_round_controller

Sequencer for the triple-DES engine. It accepts one 64-bit block request at a time and steps the subkey generator through three 16-round passes. It drives the generator's round/key counters, enable and rollover strobes, and strobes the Feistel datapath one cycle later, when each subkey is valid. It sits between the USB packet buffer (request/ack) and the key generator plus round datapath.

## Interface
Parameters:
- ROUNDS, 16, Feistel rounds per pass
- PASSES, 3, DES passes per block (key0/key1/key2)

Ports:
- clk  in  1  clock
- n_rst  in  1  reset, asynchronous, active-low
- start  in  1  block request; sampled only when ready=1
- reverse_in  in  1  0=encrypt, 1=decrypt; latched on accept
- result_ack  in  1  consumer took result; sampled only when result_valid=1
- ready  out  1  IDLE; a request is accepted this cycle if start=1
- busy  out  1  pass sequencing or DRAIN in progress
- reverse  out  1  latched direction, held stable until next accept
- key_enable  out  1  key generator advance, high for every round_count step 0..16
- round_count  out  5  0 = load step, 1..16 = round index
- key_count  out  2  current pass 0..2
- cnt_rollover  out  1  end of pass 0 or 1 (round_count=16)
- key_rollover  out  1  end of pass 2 (round_count=16)
- load_block  out  1  datapath captures input block and applies IP
- round_strobe  out  1  datapath performs one Feistel round using current subkey
- pass_done  out  1  datapath applies FP/swap for the pass just finished
- result_valid  out  1  result register holds the finished block

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: ready=1. start=1 -> RUN. reverse is latched; key_count=0; round_count=0.
- RUN: key_enable=1 every cycle; round_count steps 0,1,…,16.
  - load_block=1 on pass 0, round_count=0.
  - At round_count=16, pass 0/1: cnt_rollover=1; next cycle key_count+1, round_count=0.
  - At round_count=16, pass 2: key_rollover=1, cnt_rollover=0; next state DRAIN.
- DRAIN: one cycle, key_enable=0, round_count=0, key_count=0. Emits final round_strobe/pass_done. -> DONE.
- DONE: result_valid=1 until result_ack=1 -> IDLE. start is ignored in DONE, RUN and DRAIN.
- round_strobe = key_enable delayed one cycle, qualified by the delayed round_count≠0.
- pass_done = round_strobe whose delayed round_count = 16.
- cnt_rollover and key_rollover are never high together.
- Counters are unsigned. round_count wraps 16->0. key_count wraps 2->0 only via DRAIN. Values 17..31 and key_count=3 are unreachable; if entered, force IDLE.

## Timing
- Reset (n_rst=0, any state): IDLE.
  - ready=1.
  - All other outputs 0: reverse=0, round_count=0, key_count=0, all strobes 0, busy=0, result_valid=0.
  - Reset mid-block abandons the block with no result.
- All outputs are registered or decoded from state registers. No combinational path from inputs to outputs, except ready = (state==IDLE).
- Cycle numbering, accept edge = 0:
  - Pass p round_count=0 at cycle 1+17p; round_count=16 at 17+17p.
  - round_strobe high on cycles 3–18, 20–35, 37–52.
  - pass_done at 18, 35, 52.
  - DRAIN at cycle 52.
  - result_valid from cycle 53.
- Throughput: one block per 54 cycles minimum, with result_ack given on cycle 53 and start held high.
- result_ack and start both high in DONE: ack honored, start ignored. Earliest re-accept is the following IDLE cycle.

## Structure
- Shared package tdes_pkg:
  - state enum
  - ROUNDS, PASSES, ROUND_W=5, KEY_W=2
  - block/subkey widths (64/48), shared with key generator and datapath
- One natural sub-module: flex_counter, the round counter with rollover value 16 and rollover flag driving cnt_rollover/key_rollover.
- The pass counter and strobe delay registers stay inline.

## Test plan
- Reset, then start=1, reverse_in=0 for one cycle -> key_count 0/1/2 during cycles 1–17/18–34/35–51. cnt_rollover at 17 and 34, key_rollover at 51, result_valid at 53.
- Count round_strobe over a full block -> exactly 48 pulses. pass_done exactly at 18, 35, 52. load_block exactly at cycle 1.
- start pulsed at cycles 10, 40, 52 and in DONE -> no effect, timing unchanged. result_ack withheld 20 cycles -> result_valid held, ready=0.
- reverse_in=1 on accept, reverse_in toggled afterwards -> reverse=1 throughout, held after DONE until next accept.
- n_rst asserted at cycle 25 -> same-instant IDLE, all outputs at reset values. Next start gives the full 53-cycle sequence from key_count=0.
- Back-to-back: result_ack at cycle 53, start held high -> second accept at cycle 54, second result_valid at cycle 107.

Source files
------------

// File: rtl/tdes_pkg.sv
// Shared definitions for the triple-DES engine: sequencer state encoding,
// round/pass geometry, counter widths and the block/subkey widths used by
// the round controller, key generator and Feistel datapath.
package tdes_pkg;

  localparam int unsigned ROUNDS   = 16;  // Feistel rounds per DES pass
  localparam int unsigned PASSES   = 3;   // DES passes per block (key0/key1/key2)
  localparam int unsigned ROUND_W  = 5;   // round_count width (0 = load step, 1..16 = rounds)
  localparam int unsigned KEY_W    = 2;   // key_count width (pass index)
  localparam int unsigned BLOCK_W  = 64;  // data block width
  localparam int unsigned SUBKEY_W = 48;  // per-round subkey width

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  typedef logic [BLOCK_W-1:0]  block_t;
  typedef logic [SUBKEY_W-1:0] subkey_t;

endpackage

// File: rtl/flex_counter.sv
// Round counter with programmable rollover value.
//   clk, n_rst      clock, asynchronous active-low reset
//   clear           synchronous clear to zero (has priority over count_enable)
//   count_enable    advance by one; wraps rollover_val -> 0
//   rollover_val    terminal count
//   count_out       current count (registered)
//   rollover_flag   count_out == rollover_val, decoded from the register
module flex_counter #(
  parameter int unsigned WIDTH = 5
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             clear,
  input  logic             count_enable,
  input  logic [WIDTH-1:0] rollover_val,
  output logic [WIDTH-1:0] count_out,
  output logic             rollover_flag
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (count_enable) begin
      if (count == rollover_val) begin
        count <= '0;
      end else begin
        count <= count + WIDTH'(1);
      end
    end
  end

  assign count_out     = count;
  assign rollover_flag = (count == rollover_val);

endmodule

// File: rtl/tdes_round_controller.sv
// Triple-DES round sequencer. Accepts one block request at a time, steps the
// subkey generator through PASSES passes of ROUNDS rounds each (plus a load
// step per pass), and strobes the Feistel datapath one cycle later, when the
// subkey for that step is valid.
//   clk, n_rst     clock, asynchronous active-low reset
//   start          block request, honoured only while ready
//   reverse_in     direction for the request (0 encrypt, 1 decrypt)
//   result_ack     consumer took the result, honoured only while result_valid
//   ready          idle, a request is accepted this cycle if start=1
//   busy           pass sequencing or final drain cycle in progress
//   reverse        latched direction, stable until the next accept
//   key_enable     key generator advance (every step 0..ROUNDS)
//   round_count    0 = load step, 1..ROUNDS = round index
//   key_count      current pass
//   cnt_rollover   last step of a non-final pass
//   key_rollover   last step of the final pass
//   load_block     datapath captures the input block and applies IP
//   round_strobe   datapath performs one Feistel round
//   pass_done      datapath applies FP/swap for the pass just finished
//   result_valid   result register holds the finished block
module tdes_round_controller #(
  parameter int unsigned ROUNDS = tdes_pkg::ROUNDS,
  parameter int unsigned PASSES = tdes_pkg::PASSES
) (
  input  logic                         clk,
  input  logic                         n_rst,
  input  logic                         start,
  input  logic                         reverse_in,
  input  logic                         result_ack,
  output logic                         ready,
  output logic                         busy,
  output logic                         reverse,
  output logic                         key_enable,
  output logic [tdes_pkg::ROUND_W-1:0] round_count,
  output logic [tdes_pkg::KEY_W-1:0]   key_count,
  output logic                         cnt_rollover,
  output logic                         key_rollover,
  output logic                         load_block,
  output logic                         round_strobe,
  output logic                         pass_done,
  output logic                         result_valid
);

  import tdes_pkg::*;

  localparam logic [ROUND_W-1:0] ROUND_LAST = ROUND_W'(ROUNDS);
  localparam logic [KEY_W-1:0]   KEY_LAST   = KEY_W'(PASSES - 1);

  state_t             state;
  state_t             next_state;
  logic [ROUND_W-1:0] rc;
  logic               rc_at_last;
  logic [KEY_W-1:0]   kc;
  logic               reverse_r;
  logic               ke_d;
  logic [ROUND_W-1:0] rc_d;
  logic               illegal;
  logic               accept;
  logic               running;
  logic               last_pass;

  assign running   = (state == RUN);
  assign accept    = (state == IDLE) && start;
  assign last_pass = (kc == KEY_LAST);
  // Counter values outside the pass geometry can only come from upsets;
  // they abort the block back to IDLE.
  assign illegal   = (rc > ROUND_LAST) || (kc > KEY_LAST);

  flex_counter #(
    .WIDTH (ROUND_W)
  ) u_round_counter (
    .clk           (clk),
    .n_rst         (n_rst),
    .clear         (!running || illegal),
    .count_enable  (running),
    .rollover_val  (ROUND_LAST),
    .count_out     (rc),
    .rollover_flag (rc_at_last)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Pass counter: cleared outside RUN so every block starts at pass 0 and
  // the DRAIN cycle already shows key_count=0.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      kc <= '0;
    end else if (!running || illegal) begin
      kc <= '0;
    end else if (rc_at_last) begin
      kc <= last_pass ? '0 : kc + KEY_W'(1);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      reverse_r <= 1'b0;
    end else if (accept) begin
      reverse_r <= reverse_in;
    end
  end

  // Subkeys appear one cycle after key_enable, so datapath strobes are
  // decoded from a one-cycle-delayed copy of the key-side controls.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      ke_d <= 1'b0;
      rc_d <= '0;
    end else if (illegal) begin
      ke_d <= 1'b0;
      rc_d <= '0;
    end else begin
      ke_d <= running;
      rc_d <= rc;
    end
  end

  always_comb begin
    next_state   = state;
    ready        = 1'b0;
    busy         = 1'b0;
    key_enable   = 1'b0;
    cnt_rollover = 1'b0;
    key_rollover = 1'b0;
    load_block   = 1'b0;
    result_valid = 1'b0;

    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) begin
          next_state = RUN;
        end
      end
      RUN: begin
        busy         = 1'b1;
        key_enable   = 1'b1;
        load_block   = (rc == '0) && (kc == '0);
        cnt_rollover = rc_at_last && !last_pass;
        key_rollover = rc_at_last && last_pass;
        if (rc_at_last && last_pass) begin
          next_state = DRAIN;
        end
      end
      DRAIN: begin
        busy       = 1'b1;
        next_state = DONE;
      end
      DONE: begin
        result_valid = 1'b1;
        if (result_ack) begin
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase

    if (illegal) begin
      next_state = IDLE;
    end
  end

  assign reverse      = reverse_r;
  assign round_count  = rc;
  assign key_count    = kc;
  assign round_strobe = ke_d && (rc_d != '0);
  assign pass_done    = round_strobe && (rc_d == ROUND_LAST);

endmodule
